// File: rtl/timer_mode_ctrl.sv
// timer_mode_ctrl: key debounce, tick divider and idle/up/down/pause/done mode FSM
// for the 60 s stopwatch/countdown datapath.
module timer_mode_ctrl #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       key0,
   input  logic       key1,
   input  logic       key2,
   input  logic       key4,
   input  logic       key5,
   input  logic       key6,
   input  logic       cnt_zero,
   input  logic       cnt_max,
   output logic       clr,
   output logic       load,
   output logic       tick,
   output logic       dir_up,
   output logic       prec,
   output logic       fast,
   output logic       led,
   output logic [2:0] state
);
   localparam logic [2:0] IDLE = 3'd0, RUN_UP = 3'd1, RUN_DN = 3'd2, PAUSE = 3'd3, DONE = 3'd4;
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int VW = $clog2(CLK_HZ);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [VW-1:0] P1 = VW'(CLK_HZ - 1);
   localparam logic [VW-1:0] P2 = VW'(CLK_HZ / 2 - 1);
   localparam logic [VW-1:0] P10 = VW'(CLK_HZ / 10 - 1);
   localparam logic [VW-1:0] P20 = VW'(CLK_HZ / 20 - 1);
   logic [5:0]    raw, s1_q, s2_q, lvl_q, ev_q;
   logic [DW-1:0] deb_q [6];
   logic [2:0]    state_q, state_d, sav_q, sav_d;
   logic [VW-1:0] div_q, div_d, per_m1;
   logic          first_q, first_d, clr_q, clr_d, load_q, load_d, tick_q, tick_d;
   logic          dir_q, dir_d, prec_q, fast_q, run, last;

   // bit order: key0, key1, key2, key4, key5, key6
   assign raw = {key6, key5, key4, key2, key1, key0};

   // lvl_q is the accepted level; ev_q pulses once on an accepted press
   always_ff @(posedge clk_50M or negedge rst_n)
      if (!rst_n) begin
         s1_q <= '1;
         s2_q <= '1;
         lvl_q <= '1;
         ev_q <= '0;
         for (int i = 0; i < 6; i++) deb_q[i] <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
         for (int i = 0; i < 6; i++) begin
            ev_q[i] <= 1'b0;
            if (s2_q[i] == lvl_q[i]) deb_q[i] <= '0;
            else if (deb_q[i] == DEB_LAST) begin
               deb_q[i] <= '0;
               lvl_q[i] <= s2_q[i];
               ev_q[i] <= ~s2_q[i];
            end else deb_q[i] <= deb_q[i] + 1'b1;
         end
      end

   always_comb begin
      per_m1 = prec_q ? (fast_q ? P20 : P10) : (fast_q ? P2 : P1);
      run = state_q == RUN_UP || state_q == RUN_DN;
      last = div_q == per_m1;
      state_d = state_q;
      sav_d = sav_q;
      dir_d = dir_q;
      clr_d = 1'b0;
      load_d = 1'b0;
      tick_d = 1'b0;
      first_d = 1'b0;
      div_d = run ? (last ? '0 : div_q + 1'b1) : div_q;
      if (ev_q[2]) state_d = IDLE;
      else if (ev_q[0]) begin
         state_d = RUN_UP;
         dir_d = 1'b1;
         clr_d = 1'b1;
         div_d = '0;
      end else if (ev_q[1]) begin
         state_d = RUN_DN;
         dir_d = 1'b0;
         load_d = 1'b1;
         div_d = '0;
         first_d = 1'b1;
      end else if (ev_q[3] && run) begin
         state_d = PAUSE;
         sav_d = state_q;
      end else if (ev_q[3] && state_q == PAUSE) state_d = sav_q;
      else if (state_q == RUN_UP && last && cnt_max) state_d = DONE;
      // first_q masks the stale cnt_zero seen in the cycle the load is applied
      else if (state_q == RUN_DN && !first_q && cnt_zero) state_d = DONE;
      else tick_d = run && last;
      if (ev_q[4] || ev_q[5]) div_d = '0;
   end

   always_ff @(posedge clk_50M or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         sav_q <= RUN_UP;
         div_q <= '0;
         first_q <= 1'b0;
         clr_q <= 1'b0;
         load_q <= 1'b0;
         tick_q <= 1'b0;
         dir_q <= 1'b1;
         prec_q <= 1'b0;
         fast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sav_q <= sav_d;
         div_q <= div_d;
         first_q <= first_d;
         clr_q <= clr_d;
         load_q <= load_d;
         tick_q <= tick_d;
         dir_q <= dir_d;
         prec_q <= prec_q ^ ev_q[5];
         fast_q <= fast_q ^ ev_q[4];
      end

   assign clr = clr_q;
   assign load = load_q;
   assign tick = tick_q;
   assign dir_up = dir_q;
   assign prec = prec_q;
   assign fast = fast_q;
   assign led = state_q == DONE;
   assign state = state_q;
endmodule

// File: tb/tb_timer_mode_ctrl.sv
// tb_timer_mode_ctrl: directed bench with a behavioural BCD-counter model closing
// the cnt_zero/cnt_max loop.
module tb_timer_mode_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [5:0] kb = '1;
   logic       cnt_zero, cnt_max, clr, load, tick, dir_up, prec, fast, led;
   logic [2:0] state;
   logic [5:0] cnt = '0, preset = '0;
   int         cyc = 0, n_chk = 0, n_fail = 0, n_clr = 0, n_load = 0, n_tick = 0;
   int         t0, t1, t2, tp, tr, tc, td, nt, nc, nl;

   timer_mode_ctrl #(.CLK_HZ(100), .DEB_CYCLES(4)) dut (
      .clk_50M(clk), .rst_n(rst_n),
      .key0(kb[0]), .key1(kb[1]), .key2(kb[2]), .key4(kb[3]), .key5(kb[4]), .key6(kb[5]),
      .cnt_zero(cnt_zero), .cnt_max(cnt_max),
      .clr(clr), .load(load), .tick(tick), .dir_up(dir_up),
      .prec(prec), .fast(fast), .led(led), .state(state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (load) cnt <= preset;
      else if (clr) cnt <= '0;
      else if (tick) cnt <= dir_up ? cnt + 6'd1 : cnt - 6'd1;
   assign cnt_zero = cnt == 6'd0;
   assign cnt_max = cnt == 6'd59;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // sel: 0 tick, 1 clr, 2 load, 3 prec, 4 fast, 5 state
   task automatic wait_sig(input int sel, input int val, input int bound, input string tag,
                           output int t);
      int v;
      t = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         case (sel)
            0: v = int'(tick);
            1: v = int'(clr);
            2: v = int'(load);
            3: v = int'(prec);
            4: v = int'(fast);
            default: v = int'(state);
         endcase
         if (v == val) begin
            t = cyc;
            break;
         end
      end
      n_chk++;
      assert (t >= 0) else begin
         n_fail++;
         $error("FAIL %s timeout: observed nothing, expected value %0d within %0d cycles", tag, val, bound);
      end
   endtask

   always @(negedge clk) begin
      if (clr) n_clr++;
      if (load) n_load++;
      if (tick) n_tick++;
      if (clr || load) chk("strobe_excl", int'(clr) + int'(load) + int'(tick), 1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_state", state, 0);
      chk("rst_strobes", {clr, load, tick}, 0);
      chk("rst_dir", dir_up, 1);
      chk("rst_prec_fast", {prec, fast}, 0);
      chk("rst_led", led, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      // 1: stopwatch start, key held long, 100-clock period
      kb[0] = 1'b0;
      wait_sig(1, 1, 20, "clr", tc);
      repeat (25) @(negedge clk);
      kb[0] = 1'b1;
      chk("up_one_clr", n_clr, 1);
      chk("up_state", state, 1);
      chk("up_dir", dir_up, 1);
      wait_sig(0, 1, 150, "tick1", t1);
      chk("first_tick", t1 - tc, 100);
      wait_sig(0, 1, 150, "tick2", t2);
      chk("tick_period", t2 - t1, 100);
      // 2: pause freezes the divider phase
      wait_sig(0, 1, 150, "tick3", t0);
      repeat (50) @(negedge clk);
      kb[3] = 1'b0;
      wait_sig(5, 3, 20, "pause", tp);
      repeat (5) @(negedge clk);
      kb[3] = 1'b1;
      nt = n_tick;
      repeat (500) @(negedge clk);
      chk("pause_no_tick", n_tick - nt, 0);
      chk("pause_state", state, 3);
      kb[3] = 1'b0;
      wait_sig(5, 1, 20, "resume", tr);
      repeat (5) @(negedge clk);
      kb[3] = 1'b1;
      wait_sig(0, 1, 150, "tick_resume", t1);
      chk("pause_phase", (tp - t0) + (t1 - tr), 100);
      chk("resume_dir", dir_up, 1);
      // 3: precision / rate toggles restart the divider
      kb[5] = 1'b0;
      wait_sig(3, 1, 20, "prec_on", tp);
      kb[5] = 1'b1;
      wait_sig(0, 1, 20, "p10_t1", t1);
      chk("p10_first", t1 - tp, 10);
      wait_sig(0, 1, 20, "p10_t2", t2);
      chk("p10_period", t2 - t1, 10);
      kb[4] = 1'b0;
      wait_sig(4, 1, 20, "fast_on", tp);
      kb[4] = 1'b1;
      wait_sig(0, 1, 20, "p20_t1", t1);
      chk("p20_first", t1 - tp, 5);
      wait_sig(0, 1, 20, "p20_t2", t2);
      chk("p20_period", t2 - t1, 5);
      kb[5] = 1'b0;
      wait_sig(3, 0, 20, "prec_off", tp);
      kb[5] = 1'b1;
      wait_sig(0, 1, 80, "p2_t1", t1);
      chk("p2_first", t1 - tp, 50);
      wait_sig(0, 1, 80, "p2_t2", t2);
      chk("p2_period", t2 - t1, 50);
      chk("toggle_dir", dir_up, 1);
      // restart up-count at 5-clock period and run to full scale
      kb[5] = 1'b0;
      wait_sig(3, 1, 20, "prec_on2", tp);
      kb[5] = 1'b1;
      repeat (10) @(negedge clk);
      kb[0] = 1'b0;
      wait_sig(1, 1, 20, "restart_clr", tc);
      nt = n_tick;
      repeat (3) @(negedge clk);
      kb[0] = 1'b1;
      wait_sig(5, 4, 400, "done_up", td);
      chk("up_ticks", n_tick - nt, 59);
      chk("up_hold_max", cnt, 59);
      chk("up_led", led, 1);
      nt = n_tick;
      repeat (50) @(negedge clk);
      chk("done_no_tick", n_tick - nt, 0);
      // 4: countdown from 15
      preset = 6'd15;
      kb[1] = 1'b0;
      wait_sig(2, 1, 20, "load15", tc);
      nt = n_tick;
      chk("dn_dir", dir_up, 0);
      chk("dn_state", state, 2);
      repeat (3) @(negedge clk);
      kb[1] = 1'b1;
      wait_sig(5, 4, 200, "done_dn", td);
      chk("dn_ticks", n_tick - nt, 15);
      chk("dn_cnt", cnt, 0);
      chk("dn_led", led, 1);
      nt = n_tick;
      repeat (50) @(negedge clk);
      chk("dn_done_no_tick", n_tick - nt, 0);
      nc = n_clr;
      nl = n_load;
      kb[2] = 1'b0;
      wait_sig(5, 0, 20, "abort", td);
      chk("abort_led", led, 0);
      kb[2] = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_no_clr", n_clr - nc, 0);
      chk("abort_no_load", n_load - nl, 0);
      // preset 00 reaches DONE two cycles after load
      preset = 6'd0;
      nt = n_tick;
      kb[1] = 1'b0;
      wait_sig(2, 1, 20, "load00", tc);
      wait_sig(5, 4, 10, "done00", td);
      chk("zero_latency", td - tc, 2);
      chk("zero_no_tick", n_tick - nt, 0);
      kb[1] = 1'b1;
      repeat (10) @(negedge clk);
      kb[2] = 1'b0;
      wait_sig(5, 0, 20, "abort2", td);
      kb[2] = 1'b1;
      repeat (10) @(negedge clk);
      // 5: bounce rejected, key2 beats key0
      nc = n_clr;
      for (int i = 0; i < 10; i++) begin
         kb[0] = 1'b0;
         repeat (2) @(negedge clk);
         kb[0] = 1'b1;
         repeat (2) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk("bounce_no_clr", n_clr - nc, 0);
      chk("bounce_state", state, 0);
      kb[0] = 1'b0;
      kb[2] = 1'b0;
      repeat (12) @(negedge clk);
      kb = '1;
      repeat (10) @(negedge clk);
      chk("prio_state", state, 0);
      chk("prio_no_clr", n_clr - nc, 0);
      // 6: asynchronous reset mid-countdown
      preset = 6'd15;
      kb[1] = 1'b0;
      wait_sig(2, 1, 20, "load_rst", tc);
      repeat (3) @(negedge clk);
      kb[1] = 1'b1;
      repeat (20) @(negedge clk);
      chk("pre_rst_state", state, 2);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_state", state, 0);
      chk("arst_led_tick", {led, tick}, 0);
      chk("arst_dir", dir_up, 1);
      chk("arst_prec", prec, 0);
      repeat (3) @(negedge clk);
      nc = n_clr;
      nl = n_load;
      nt = n_tick;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_strobes", (n_clr - nc) + (n_load - nl) + (n_tick - nt), 0);
      chk("post_rst_state", state, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
